// File: rtl/accel_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// accel_req_arbiter_if
//
// Purpose:
//   Bundles the request/response handshake between NumReq requesters, the
//   accelerator arbiter and Ara's single accelerator channel.
//   Signal names use the arbiter's point of view: _i is driven into the
//   arbiter and _o is driven by it.
//
// Signals:
//   req_i            NumReq*ReqWidth  requester payloads, slice k = requester k
//   req_valid_i      NumReq           request valid per requester
//   req_ready_o      NumReq           request accepted per requester (one-hot/zero)
//   resp_o           RespWidth        response payload, broadcast
//   resp_valid_o     NumReq           response valid, one-hot at FIFO-head requester
//   resp_ready_i     NumReq           response ready per requester
//   acc_req_o        ReqWidth         payload to Ara
//   acc_req_valid_o  1                request valid to Ara
//   acc_req_ready_i  1                Ara ready
//   acc_resp_i       RespWidth        Ara response payload
//   acc_resp_valid_i 1                Ara response valid
//   acc_resp_ready_o 1                ready to Ara
//
// Modports:
//   slave  - used by the arbiter itself
//   master - used by the surrounding requesters / Ara side (or a testbench)
//
// The parameters must match those of the accel_req_arbiter instance that
// connects to this interface.
// ---------------------------------------------------------------------------
interface accel_req_arbiter_if #(
    parameter int NumReq    = 2,
    parameter int ReqWidth  = 160,
    parameter int RespWidth = 128
);
    // Requester side
    logic [NumReq*ReqWidth-1:0] req_i;
    logic [NumReq-1:0]          req_valid_i;
    logic [NumReq-1:0]          req_ready_o;
    logic [RespWidth-1:0]       resp_o;
    logic [NumReq-1:0]          resp_valid_o;
    logic [NumReq-1:0]          resp_ready_i;

    // Ara side
    logic [ReqWidth-1:0]        acc_req_o;
    logic                       acc_req_valid_o;
    logic                       acc_req_ready_i;
    logic [RespWidth-1:0]       acc_resp_i;
    logic                       acc_resp_valid_i;
    logic                       acc_resp_ready_o;

    modport slave (
        input  req_i,
        input  req_valid_i,
        output req_ready_o,
        output resp_o,
        output resp_valid_o,
        input  resp_ready_i,
        output acc_req_o,
        output acc_req_valid_o,
        input  acc_req_ready_i,
        input  acc_resp_i,
        input  acc_resp_valid_i,
        output acc_resp_ready_o
    );

    modport master (
        output req_i,
        output req_valid_i,
        input  req_ready_o,
        input  resp_o,
        input  resp_valid_o,
        output resp_ready_i,
        input  acc_req_o,
        input  acc_req_valid_o,
        output acc_req_ready_i,
        output acc_resp_i,
        output acc_resp_valid_i,
        input  acc_resp_ready_o
    );
endinterface

// File: rtl/accel_req_arbiter.sv
// ---------------------------------------------------------------------------
// accel_req_arbiter
//
// Purpose:
//   Shares Ara's single accelerator request/response channel between NumReq
//   requesters (e.g. CVA6 and a trace dispatcher).
//   - Round-robin arbitration; once a request has been offered to Ara and not
//     taken, the grant is locked to that requester until the handshake.
//   - Every accepted request pushes its requester index into an in-order ID
//     FIFO (depth MaxOutstanding).
//   - Each Ara response is routed to the requester at the FIFO head.
//   - Pure pass-through on the payloads: zero added latency.
//
// Parameters:
//   NumReq         number of requesters (>= 2)
//   ReqWidth       request payload width
//   RespWidth      response payload width
//   MaxOutstanding ID FIFO depth = max accepted requests awaiting response (>= 1)
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   bus            accel_req_arbiter_if.slave, request/response handshakes
//   perf_grant_o   NumReq*32, per-requester accepted-request counters
//   perf_stall_o   32, cycles with a request offered to Ara but not taken
//
// Build options:
//   ACC_ARB_PERF_EN  when defined, the perf counters are implemented (32-bit,
//                    wrapping, cleared by rst_i); when undefined the perf
//                    outputs are tied to zero and no counter flops exist.
// ---------------------------------------------------------------------------
module accel_req_arbiter #(
    parameter int NumReq         = 2,
    parameter int ReqWidth       = 160,
    parameter int RespWidth      = 128,
    parameter int MaxOutstanding = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    accel_req_arbiter_if.slave     bus,
    output logic [NumReq*32-1:0]   perf_grant_o,
    output logic [31:0]            perf_stall_o
);

    localparam int IdxW = $clog2(NumReq);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // -----------------------------------------------------------------------
    // State
    // -----------------------------------------------------------------------
    logic [0:0]      state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;

    logic [IdxW-1:0] id_mem_q [MaxOutstanding];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    // -----------------------------------------------------------------------
    // Combinational signals
    // -----------------------------------------------------------------------
    logic [ReqWidth-1:0] req_arr [NumReq];
    logic                win_found;
    logic [IdxW-1:0]     win_idx;
    logic [IdxW-1:0]     cand_idx;
    logic [IdxW-1:0]     sel_idx;
    logic                fifo_full;
    logic                fifo_empty;
    logic [IdxW-1:0]     head_id;
    logic                acc_req_valid;
    logic                handshake;
    logic                acc_resp_ready;
    logic                push;
    logic                pop;
    logic [NumReq-1:0]   req_ready;
    logic [NumReq-1:0]   resp_valid;

    // Unpack the flattened request bus and build per-requester strobes.
    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_req
            assign req_arr[gi]    = bus.req_i[gi*ReqWidth +: ReqWidth];
            // Only the selected requester sees ready, and only on a handshake.
            assign req_ready[gi]  = handshake && (sel_idx == IdxW'(gi));
            // Response valid is steered to whoever owns the oldest request.
            assign resp_valid[gi] = !rst_i && !fifo_empty && bus.acc_resp_valid_i
                                    && (head_id == IdxW'(gi));
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Round-robin winner: first valid requester at or above rr_ptr_q,
    // wrapping modulo NumReq.
    // -----------------------------------------------------------------------
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_idx  = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand_idx = IdxW'((int'(rr_ptr_q) + i) % NumReq);
            if (!win_found && bus.req_valid_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Request path
    // -----------------------------------------------------------------------
    assign fifo_full  = (count_q == CntW'(MaxOutstanding));
    assign fifo_empty = (count_q == '0);

    // While holding, the locked requester is still driving valid, so the
    // channel stays valid regardless of what the other requesters do.
    assign sel_idx       = (state_q == ST_HOLD) ? grant_q : win_idx;
    // A full FIFO blocks new grants even when a pop happens this cycle, which
    // keeps the ready path free of the response handshake.
    assign acc_req_valid = !rst_i && !fifo_full
                           && ((state_q == ST_HOLD) || win_found);
    assign handshake     = acc_req_valid && bus.acc_req_ready_i;
    assign push          = handshake;

    // -----------------------------------------------------------------------
    // Response path
    // -----------------------------------------------------------------------
    assign head_id        = id_mem_q[rd_ptr_q];
    assign acc_resp_ready = !rst_i && !fifo_empty && bus.resp_ready_i[head_id];
    assign pop            = bus.acc_resp_valid_i && acc_resp_ready;

    // -----------------------------------------------------------------------
    // Interface outputs
    // -----------------------------------------------------------------------
    assign bus.acc_req_o        = req_arr[sel_idx];
    assign bus.acc_req_valid_o  = acc_req_valid;
    assign bus.req_ready_o      = req_ready;
    assign bus.resp_o           = bus.acc_resp_i;
    assign bus.resp_valid_o     = resp_valid;
    assign bus.acc_resp_ready_o = acc_resp_ready;

    // -----------------------------------------------------------------------
    // FSM and round-robin pointer
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_ARB: begin
                // Offered but not taken: lock the winner so the payload seen
                // by Ara cannot change until it is accepted.
                if (!handshake && acc_req_valid) begin
                    grant_d = win_idx;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (handshake) begin
                    state_d = ST_ARB;
                end
            end
            default: begin
                state_d = ST_ARB;
            end
        endcase
        if (handshake) begin
            rr_ptr_d = (sel_idx == IdxW'(NumReq - 1)) ? '0 : sel_idx + IdxW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_ARB;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // -----------------------------------------------------------------------
    // ID FIFO
    // -----------------------------------------------------------------------
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while count_q says valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem_q[wr_ptr_q] <= sel_idx;
        end
    end

    // -----------------------------------------------------------------------
    // Performance counters
    // -----------------------------------------------------------------------
`ifdef ACC_ARB_PERF_EN
    logic [31:0] stall_cnt_q;

    generate
        for (genvar gi = 0; gi < NumReq; gi++) begin : g_perf
            logic [31:0] grant_cnt_q;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    grant_cnt_q <= '0;
                end else if (req_ready[gi]) begin
                    grant_cnt_q <= grant_cnt_q + 32'd1;
                end
            end

            assign perf_grant_o[gi*32 +: 32] = grant_cnt_q;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_q <= '0;
        end else if (acc_req_valid && !bus.acc_req_ready_i) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_stall_o = stall_cnt_q;
`else
    assign perf_grant_o = '0;
    assign perf_stall_o = '0;
`endif

    // -----------------------------------------------------------------------
    // A response with nothing outstanding has no owner and would be lost.
    // -----------------------------------------------------------------------
`ifndef SYNTHESIS
    resp_without_request_a: assert property (
        @(posedge clk_i) disable iff (rst_i)
        !(bus.acc_resp_valid_i && fifo_empty)
    );
`endif

endmodule
